// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_alu
// Description : Handshaked ALU; shifts iterate one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] c_cnt_one = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic [SHW-1:0]  r_cnt;
  logic [1:0]      r_shift_kind;

  logic [SHW-1:0]  w_shamt;
  logic            w_is_shift;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_step;

  assign w_shamt = op_b[SHW-1:0];

  // Shifts return op_a here; a non-zero shamt is handled iteratively.
  always_comb begin
    w_is_shift = 1'b0;
    w_alu      = op_a + op_b;
    case (alu_ctrl)
      4'b1000, 4'b1010:         w_alu = op_a - op_b;
      4'b0001, 4'b0101, 4'b1101: begin
        w_is_shift = 1'b1;
        w_alu      = op_a;
      end
      4'b0010: w_alu = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b0011: w_alu = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      4'b0100: w_alu = op_a ^ op_b;
      4'b0110: w_alu = op_a | op_b;
      4'b0111: w_alu = op_a & op_b;
      default: w_alu = op_a + op_b;
    endcase
  end

  // alu_ctrl[3:2] distinguishes SLL (00), SRL (01) and SRA (11).
  always_comb begin
    case (r_shift_kind)
      2'b00:   w_step = {r_result[XLEN-2:0], 1'b0};
      2'b01:   w_step = {1'b0, r_result[XLEN-1:1]};
      default: w_step = {r_result[XLEN-1], r_result[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_cnt        <= '0;
      r_shift_kind <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_result   <= w_alu;
            r_zero     <= (w_alu == '0);
            if (w_is_shift && (w_shamt != '0)) begin
              r_cnt        <= w_shamt;
              r_shift_kind <= alu_ctrl[3:2];
              r_state      <= S_SHIFT;
            end else begin
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_result <= w_step;
          r_zero   <= (w_step == '0);
          r_cnt    <= r_cnt - c_cnt_one;
          if (r_cnt == c_cnt_one) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_alu
// Description : Scoreboard bench for multicycle_alu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [XLEN-1:0] exp_res_q[$];
  int              exp_lat_q[$];

  multicycle_alu #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] model(input logic [3:0] c,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (c)
      4'd0:         return a + b;
      4'd8, 4'd10:  return a - b;
      4'd1:         return a << sh;
      4'd5:         return a >> sh;
      4'd13:        return $unsigned($signed(a) >>> sh);
      4'd2:         return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:         return (a < b) ? 32'd1 : 32'd0;
      4'd4:         return a ^ b;
      4'd6:         return a | b;
      4'd7:         return a & b;
      default:      return a + b;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] c, input logic [XLEN-1:0] b);
    if ((c == 4'd1 || c == 4'd5 || c == 4'd13) && b[4:0] != 5'd0)
      return 1 + int'(b[4:0]);
    return 1;
  endfunction

  // Waits for in_ready, drives one accepted request and records its expectation.
  task automatic issue(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready got %b want 1", in_ready);
    end
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    exp_res_q.push_back(model(c, a, b));
    exp_lat_q.push_back(model_lat(c, b));
  endtask

  // Called 1 time unit after the accepting edge; counts cycles until out_valid.
  task automatic collect(input bit consume, output logic [XLEN-1:0] r, output logic z,
                         output int lat, output bit busy_ok, output bit timeout);
    lat     = 1;
    busy_ok = 1'b1;
    timeout = 1'b0;
    while (!out_valid) begin
      if (in_ready) busy_ok = 1'b0;
      if (lat >= 100) begin
        timeout = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    r = result;
    z = zero;
    if (consume && !timeout) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_cmp++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (result !== '0)      begin n_fail++; $display("FAIL rst_result got %h want 0", result); end
    n_cmp++; if (zero !== 1'b0)      begin n_fail++; $display("FAIL rst_zero got %b want 0", zero); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rel_in_ready got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL first_edge_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    logic [XLEN-1:0] r, er;
    logic z;
    int lat, el;
    bit busy, to;
    issue(4'b0000, 32'd5, 32'd7);
    collect(1'b1, r, z, lat, busy, to);
    er = exp_res_q.pop_front();
    el = exp_lat_q.pop_front();
    n_cmp++; if (to)          begin n_fail++; $display("FAIL add_timeout got timeout want out_valid"); end
    n_cmp++; if (r !== 32'd12) begin n_fail++; $display("FAIL add_result got %h want %h", r, 32'd12); end
    n_cmp++; if (r !== er)     begin n_fail++; $display("FAIL add_model got %h want %h", r, er); end
    n_cmp++; if (z !== 1'b0)   begin n_fail++; $display("FAIL add_zero got %b want 0", z); end
    n_cmp++; if (lat != el)    begin n_fail++; $display("FAIL add_latency got %0d want %0d", lat, el); end
  endtask

  task automatic test_sub_zero();
    logic [XLEN-1:0] r, er;
    logic z;
    int lat, el;
    bit busy, to;
    logic [3:0] codes[2];
    codes[0] = 4'b1000;
    codes[1] = 4'b1010;
    foreach (codes[i]) begin
      issue(codes[i], 32'h1234, 32'h1234);
      collect(1'b1, r, z, lat, busy, to);
      er = exp_res_q.pop_front();
      el = exp_lat_q.pop_front();
      n_cmp++; if (to || r !== er) begin n_fail++; $display("FAIL sub%0d_result got %h want %h", i, r, er); end
      n_cmp++; if (z !== 1'b1)     begin n_fail++; $display("FAIL sub%0d_zero got %b want 1", i, z); end
      n_cmp++; if (lat != el)      begin n_fail++; $display("FAIL sub%0d_latency got %0d want %0d", i, lat, el); end
    end
  endtask

  task automatic test_slt();
    logic [XLEN-1:0] r;
    logic z;
    int lat;
    bit busy, to;
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
    collect(1'b1, r, z, lat, busy, to);
    void'(exp_res_q.pop_front());
    void'(exp_lat_q.pop_front());
    n_cmp++; if (to || r !== 32'd1) begin n_fail++; $display("FAIL slt_result got %h want 1", r); end
    issue(4'b0011, 32'hFFFF_FFFF, 32'd1);
    collect(1'b1, r, z, lat, busy, to);
    void'(exp_res_q.pop_front());
    void'(exp_lat_q.pop_front());
    n_cmp++; if (to || r !== 32'd0) begin n_fail++; $display("FAIL sltu_result got %h want 0", r); end
    n_cmp++; if (z !== 1'b1)        begin n_fail++; $display("FAIL sltu_zero got %b want 1", z); end
  endtask

  task automatic test_sra();
    logic [XLEN-1:0] r;
    logic z;
    int lat;
    bit busy, to;
    issue(4'b1101, 32'h8000_0000, 32'd4);
    collect(1'b1, r, z, lat, busy, to);
    void'(exp_res_q.pop_front());
    void'(exp_lat_q.pop_front());
    n_cmp++; if (to || r !== 32'hF800_0000) begin n_fail++; $display("FAIL sra_result got %h want f8000000", r); end
    n_cmp++; if (lat != 5)                  begin n_fail++; $display("FAIL sra_latency got %0d want 5", lat); end
    n_cmp++; if (!busy)                     begin n_fail++; $display("FAIL sra_in_ready got 1 want 0 while busy"); end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] r, er, a, b;
    logic z;
    int lat, el;
    bit busy, to;
    logic [3:0] codes[14];
    codes = '{4'd0, 4'd8, 4'd10, 4'd1, 4'd5, 4'd13, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd9, 4'd15, 4'd11};
    for (int i = 0; i < 28; i++) begin
      logic [3:0] c;
      c = codes[i % 14];
      a = $urandom;
      b = (i % 5 == 0) ? 32'h0000_0020 * $urandom_range(0, 7) : $urandom;
      if (i == 3) b = 32'd31;
      issue(c, a, b);
      collect(1'b1, r, z, lat, busy, to);
      er = exp_res_q.pop_front();
      el = exp_lat_q.pop_front();
      n_cmp++; if (to || r !== er)    begin n_fail++; $display("FAIL op%0d_ctrl%0d_result got %h want %h", i, c, r, er); end
      n_cmp++; if (z !== (er == '0))  begin n_fail++; $display("FAIL op%0d_zero got %b want %b", i, z, (er == '0)); end
      n_cmp++; if (lat != el)         begin n_fail++; $display("FAIL op%0d_latency got %0d want %0d", i, lat, el); end
    end
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0] r, er;
    logic z;
    int lat, el;
    bit busy, to;
    issue(4'b0000, 32'd100, 32'd200);
    collect(1'b0, r, z, lat, busy, to);
    er = exp_res_q.pop_front();
    void'(exp_lat_q.pop_front());
    n_cmp++; if (to || r !== er) begin n_fail++; $display("FAIL bp_result got %h want %h", r, er); end
    alu_ctrl = 4'b1000;
    op_a     = 32'd50;
    op_b     = 32'd8;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_cmp++; if (result !== er || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d got %h/%b want %h/1", k, result, out_valid, er); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d got %b want 0", k, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_consume got valid %b ready %b want 0/1", out_valid, in_ready); end
    exp_res_q.push_back(model(4'b1000, 32'd50, 32'd8));
    exp_lat_q.push_back(1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    collect(1'b1, r, z, lat, busy, to);
    er = exp_res_q.pop_front();
    el = exp_lat_q.pop_front();
    n_cmp++; if (to || r !== 32'd42 || r !== er) begin n_fail++; $display("FAIL bp_next_result got %h want %h", r, er); end
    n_cmp++; if (lat != el) begin n_fail++; $display("FAIL bp_next_latency got %0d want %0d", lat, el); end
  endtask

  task automatic test_reset_mid_shift();
    logic [XLEN-1:0] r, er;
    logic z;
    int lat, el;
    bit busy, to;
    issue(4'b0001, 32'h0000_0001, 32'd31);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    exp_res_q.delete();
    exp_lat_q.delete();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
    n_cmp++; if (result !== '0)      begin n_fail++; $display("FAIL abort_result got %h want 0", result); end
    n_cmp++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL abort_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_release got ready %b valid %b want 1/0", in_ready, out_valid); end
    issue(4'b0101, 32'hF000_0000, 32'd3);
    collect(1'b1, r, z, lat, busy, to);
    er = exp_res_q.pop_front();
    el = exp_lat_q.pop_front();
    n_cmp++; if (to || r !== er) begin n_fail++; $display("FAIL post_abort_result got %h want %h", r, er); end
    n_cmp++; if (lat != el)      begin n_fail++; $display("FAIL post_abort_latency got %0d want %0d", lat, el); end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_ctrl  = 4'b0000;
    op_a      = '0;
    op_b      = '0;
    test_reset();
    test_add();
    test_sub_zero();
    test_slt();
    test_sra();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand/result width; the shift amount is op_b[$clog2(XLEN)-1:0].
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, operation request.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept an operation.
REQ-006 The block SHALL have port alu_ctrl, input, 4, operation select from ALU control.
REQ-007 The block SHALL have ports op_a and op_b, input, XLEN each, operands.
REQ-008 The block SHALL have port out_valid, output, 1, result available.
REQ-009 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 The block SHALL have port result, output, XLEN, registered result.
REQ-011 The block SHALL have port zero, output, 1, registered (result == 0).

Function
REQ-012 The block SHALL decode alu_ctrl as follows:
- 0000 ADD; 1000 SUB; 1010 SUB
- 0001 SLL; 0101 SRL; 1101 SRA
- 0010 SLT (signed); 0011 SLTU
- 0100 XOR; 0110 OR; 0111 AND
- any other code: ADD
REQ-013 The block SHALL implement the FSM states IDLE, SHIFT and DONE; reset enters IDLE.
REQ-014 in_ready SHALL be 1 only in IDLE; an operation is accepted when in_valid && in_ready at a rising clk edge; alu_ctrl and the operands are sampled only at acceptance.
REQ-015 For non-shift operations, the block SHALL compute the result at acceptance and go IDLE -> DONE; out_valid SHALL be 1 in the cycle after acceptance (latency 1).
REQ-016 For shift operations with shamt = 0, the block SHALL go IDLE -> DONE with result = op_a (latency 1).
REQ-017 For shift operations with shamt > 0, the block SHALL:
- load op_a into the working register, load shamt into a down-counter, and enter SHIFT
- shift by one bit per cycle (SRA replicates the MSB; SLL/SRL fill with 0) and decrement the counter
- enter DONE when the counter reaches 0
- give total latency 1 + shamt cycles from acceptance to out_valid
REQ-018 Arithmetic SHALL be modulo 2^XLEN with carry/overflow discarded; SLT/SLTU results SHALL be zero-extended 0 or 1.
REQ-019 In DONE, out_valid SHALL be 1, and result/zero SHALL hold stable until out_valid && out_ready; at that edge the block SHALL return to IDLE.
REQ-020 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.
REQ-021 No new operation SHALL be accepted in the cycle a result is consumed; the minimum issue interval is 2 cycles.
REQ-022 zero SHALL be updated only when result is updated.

Reset
REQ-023 While reset is high, the block SHALL hold state IDLE, in_ready 0, out_valid 0, result 0, zero 0 and shift counter 0, asynchronously.
REQ-024 After reset deasserts, in_ready SHALL be 1 from the first rising clk edge.
REQ-025 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no result delivered; the pending result is discarded.

Verification
REQ-026 ADD: op_a=5, op_b=7, alu_ctrl=0000 -> out_valid 1 cycle later, result=12, zero=0.
REQ-027 SUB to zero: op_a=op_b=0x1234, alu_ctrl=1000 -> result=0, zero=1; alu_ctrl=1010 -> same.
REQ-028 SRA: op_a=0x80000000, op_b=4, alu_ctrl=1101 -> out_valid after 5 cycles, result=0xF8000000; in_ready=0 throughout.
REQ-029 SLT/SLTU: op_a=0xFFFFFFFF, op_b=1 -> SLT result=1, SLTU result=0.
REQ-030 Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 -> result stable, no new accept; raise out_ready -> IDLE, then next op accepted.
REQ-031 Reset mid-SLL (shamt=31, after 10 cycles) -> out_valid=0, result=0, in_ready=1 after reset release; a new op completes normally.
